// File: rtl/seven_segment_scanner_if.sv
// Data and display-pin bundle for seven_segment_scanner; master = data source, slave = scanner.
// Optional SEG_DIMMING_EN adds the brightness field.
interface seven_segment_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    blank_lz;
    logic                    load;
`ifdef SEG_DIMMING_EN
    logic [3:0]              brightness;
`endif
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

`ifdef SEG_DIMMING_EN
    modport master (output digits, dp_in, digit_en, blank_lz, load, brightness,
                    input  seg, dp, an, frame_done);
    modport slave  (input  digits, dp_in, digit_en, blank_lz, load, brightness,
                    output seg, dp, an, frame_done);
`else
    modport master (output digits, dp_in, digit_en, blank_lz, load,
                    input  seg, dp, an, frame_done);
    modport slave  (input  digits, dp_in, digit_en, blank_lz, load,
                    output seg, dp, an, frame_done);
`endif
endinterface

// File: rtl/seven_segment_scanner.sv
// Multi-digit common-anode seven-segment scanner with guard blanking, frame-aligned double buffering,
// leading-zero blanking and hex decode. Optional PWM dimming when SEG_DIMMING_EN is defined.
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    seven_segment_scanner_if.slave bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [PW-1:0]           presc_r;
    logic [IW-1:0]           idx_r;
    logic [4*NUM_DIGITS-1:0] pend_digits_r, act_digits_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r, act_dp_r;
    logic [NUM_DIGITS-1:0]   pend_en_r, act_en_r;
    logic                    pend_valid_r;
    logic [6:0]              seg_r;
    logic                    dp_r;
    logic [NUM_DIGITS-1:0]   an_r;
    logic                    frame_done_r;
`ifdef SEG_DIMMING_EN
    logic [3:0]              pend_bright_r, act_bright_r, pwm_r;
`endif

    logic                    slot_end_s, frame_wrap_s, lit_s, show_s, drive_s, zero_run_s;
    logic                    cur_en_s, cur_dp_s, cur_blank_s;
    logic [3:0]              cur_nib_s;
    logic [NUM_DIGITS-1:0]   blank_s, an_next_s;
    logic [6:0]              seg_next_s;
    logic                    dp_next_s;

    // Leading-zero blanking: a digit blanks while every digit above it (inclusive) is a bare zero.
    always_comb begin
        zero_run_s = 1'b1;
        blank_s    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run_s = zero_run_s && (act_digits_r[4*i +: 4] == 4'h0) && !act_dp_r[i];
            blank_s[i] = bus.blank_lz && zero_run_s;
        end
    end

    // Select the current slot's digit and form the next output values.
    always_comb begin
        slot_end_s   = (presc_r == PRESC_LAST);
        frame_wrap_s = slot_end_s && (idx_r == IDX_LAST);
        cur_nib_s    = 4'h0;
        cur_en_s     = 1'b0;
        cur_dp_s     = 1'b0;
        cur_blank_s  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_r == IW'(i)) begin
                cur_nib_s   = act_digits_r[4*i +: 4];
                cur_en_s    = act_en_r[i];
                cur_dp_s    = act_dp_r[i];
                cur_blank_s = blank_s[i];
            end else begin
                cur_nib_s   = cur_nib_s;
            end
        end
        lit_s  = (presc_r >= GUARD_END);
        show_s = lit_s && cur_en_s && !cur_blank_s;
`ifdef SEG_DIMMING_EN
        drive_s = show_s && (pwm_r < act_bright_r);
`else
        drive_s = show_s;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_next_s[i] = !(drive_s && (idx_r == IW'(i)));
        end
        if (show_s) begin
            seg_next_s = hex_decode(cur_nib_s);
            dp_next_s  = ~cur_dp_s;
        end else begin
            seg_next_s = 7'h7F;
            dp_next_s  = 1'b1;
        end
    end

    // Scan counters, double buffer and registered pin outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r       <= '0;
            idx_r         <= '0;
            pend_digits_r <= '0;
            pend_dp_r     <= '0;
            pend_en_r     <= '0;
            pend_valid_r  <= 1'b0;
            act_digits_r  <= '0;
            act_dp_r      <= '0;
            act_en_r      <= '0;
            seg_r         <= 7'h7F;
            dp_r          <= 1'b1;
            an_r          <= '1;
            frame_done_r  <= 1'b0;
`ifdef SEG_DIMMING_EN
            pend_bright_r <= 4'h0;
            act_bright_r  <= 4'h0;
            pwm_r         <= 4'h0;
`endif
        end else begin
            if (slot_end_s) begin
                presc_r <= '0;
                idx_r   <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
            end else begin
                presc_r <= presc_r + PW'(1);
            end
            // Boundary applies the pending copy held before this edge; a coincident load stays pending.
            if (frame_wrap_s && pend_valid_r) begin
                act_digits_r <= pend_digits_r;
                act_dp_r     <= pend_dp_r;
                act_en_r     <= pend_en_r;
`ifdef SEG_DIMMING_EN
                act_bright_r <= pend_bright_r;
`endif
            end
            if (bus.load) begin
                pend_digits_r <= bus.digits;
                pend_dp_r     <= bus.dp_in;
                pend_en_r     <= bus.digit_en;
                pend_valid_r  <= 1'b1;
`ifdef SEG_DIMMING_EN
                pend_bright_r <= bus.brightness;
`endif
            end else if (frame_wrap_s) begin
                pend_valid_r  <= 1'b0;
            end
`ifdef SEG_DIMMING_EN
            pwm_r         <= pwm_r + 4'd1;
`endif
            seg_r         <= seg_next_s;
            dp_r          <= dp_next_s;
            an_r          <= an_next_s;
            frame_done_r  <= frame_wrap_s;
        end
    end

    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.an         = an_r;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed self-checking bench for seven_segment_scanner (NUM_DIGITS=4, PRESCALE=8, GUARD_CYCLES=2).
module tb_seven_segment_scanner;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    seven_segment_scanner_if #(.NUM_DIGITS(4)) bus ();

    seven_segment_scanner #(.NUM_DIGITS(4), .PRESCALE(8), .GUARD_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Captured frame words {an, seg, dp, frame_done} and per-slot lit expectations.
    logic [12:0] cap_w [32];
    logic [3:0]  e_an  [4];
    logic [6:0]  e_seg [4];
    logic        e_dp  [4];

    function automatic logic [12:0] exp_at(input int k);
        int s;
        int p;
        logic fd;
        s  = k / 8;
        p  = k % 8;
        fd = (k == 31);
        if (p < 2) return {4'hF, 7'h7F, 1'b1, fd};
        return {e_an[s], e_seg[s], e_dp[s], fd};
    endfunction

    task automatic set_dark();
        for (int s = 0; s < 4; s++) begin
            e_an[s] = 4'hF; e_seg[s] = 7'h7F; e_dp[s] = 1'b1;
        end
    endtask

    task automatic wait_frame();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_frame: frame_done got 0 for 80 cycles, required a pulse");
        end
    endtask

    task automatic capture_frame();
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            cap_w[k] = {bus.an, bus.seg, bus.dp, bus.frame_done};
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpi, input logic [3:0] en);
        @(negedge clk);
        bus.digits = d; bus.dp_in = dpi; bus.digit_en = en; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got %b required %b", {bus.an, bus.seg, bus.dp, bus.frame_done},
                     {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        reset = 1'b0;
        wait_frame();
        set_dark();
        for (int f = 0; f < 2; f++) begin
            capture_frame();
            for (int k = 0; k < 32; k++) begin
                checks++;
                if (cap_w[k] !== exp_at(k)) begin
                    errors++;
                    $display("FAIL reset_dark f=%0d k=%0d got %b required %b", f, k, cap_w[k], exp_at(k));
                end
            end
        end
    endtask

    task automatic test_basic_scan();
        bus.blank_lz = 1'b0;
        do_load(16'h1234, 4'h0, 4'hF);
        wait_frame();
        e_an[0] = 4'b1110; e_seg[0] = 7'b0011001; e_dp[0] = 1'b1;
        e_an[1] = 4'b1101; e_seg[1] = 7'b0110000; e_dp[1] = 1'b1;
        e_an[2] = 4'b1011; e_seg[2] = 7'b0100100; e_dp[2] = 1'b1;
        e_an[3] = 4'b0111; e_seg[3] = 7'b1111001; e_dp[3] = 1'b1;
        capture_frame();
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (cap_w[k] !== exp_at(k)) begin
                errors++;
                $display("FAIL basic_scan k=%0d got %b required %b", k, cap_w[k], exp_at(k));
            end
        end
    endtask

    task automatic test_leading_zero();
        bus.blank_lz = 1'b1;
        do_load(16'h0070, 4'h0, 4'hF);
        wait_frame();
        set_dark();
        e_an[0] = 4'b1110; e_seg[0] = 7'b1000000;
        e_an[1] = 4'b1101; e_seg[1] = 7'b1111000;
        capture_frame();
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (cap_w[k] !== exp_at(k)) begin
                errors++;
                $display("FAIL lz_0070 k=%0d got %b required %b", k, cap_w[k], exp_at(k));
            end
        end
        do_load(16'h0000, 4'h0, 4'hF);
        wait_frame();
        set_dark();
        e_an[0] = 4'b1110; e_seg[0] = 7'b1000000;
        capture_frame();
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (cap_w[k] !== exp_at(k)) begin
                errors++;
                $display("FAIL lz_0000 k=%0d got %b required %b", k, cap_w[k], exp_at(k));
            end
        end
    endtask

    task automatic test_tear_free();
        logic [12:0] w;
        bus.blank_lz = 1'b0;
        do_load(16'h5555, 4'h0, 4'hF);
        wait_frame();
        for (int s = 0; s < 4; s++) begin
            e_an[s] = ~(4'b0001 << s); e_seg[s] = 7'b0010010; e_dp[s] = 1'b1;
        end
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            w = {bus.an, bus.seg, bus.dp, bus.frame_done};
            checks++;
            if (w !== exp_at(k)) begin
                errors++;
                $display("FAIL tear_old k=%0d got %b required %b", k, w, exp_at(k));
            end
            if (k == 4)  begin bus.digits = 16'h1111; bus.load = 1'b1; end
            else if (k == 12) begin bus.digits = 16'h2222; bus.load = 1'b1; end
            else bus.load = 1'b0;
        end
        for (int s = 0; s < 4; s++) e_seg[s] = 7'b0100100;
        capture_frame();
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (cap_w[k] !== exp_at(k)) begin
                errors++;
                $display("FAIL tear_new k=%0d got %b required %b", k, cap_w[k], exp_at(k));
            end
        end
    endtask

    task automatic test_enable_dp();
        bus.blank_lz = 1'b0;
        do_load(16'h4321, 4'b0001, 4'b0101);
        wait_frame();
        set_dark();
        e_an[0] = 4'b1110; e_seg[0] = 7'b1111001; e_dp[0] = 1'b0;
        e_an[2] = 4'b1011; e_seg[2] = 7'b0110000; e_dp[2] = 1'b1;
        capture_frame();
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (cap_w[k] !== exp_at(k)) begin
                errors++;
                $display("FAIL enable_dp k=%0d got %b required %b", k, cap_w[k], exp_at(k));
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [12:0] w;
        logic [12:0] x;
        wait_frame();
        repeat (18) @(negedge clk);
        bus.digits = 16'h8888; bus.dp_in = 4'h0; bus.digit_en = 4'hF; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        w = {bus.an, bus.seg, bus.dp, bus.frame_done};
        checks++;
        if (w !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midscan_reset got %b required %b", w, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            w = {bus.an, bus.seg, bus.dp, bus.frame_done};
            x = {4'hF, 7'h7F, 1'b1, ((k == 32) || (k == 64))};
            checks++;
            if (w !== x) begin
                errors++;
                $display("FAIL midscan_restart k=%0d got %b required %b", k, w, x);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.digits   = 16'h0000;
        bus.dp_in    = 4'h0;
        bus.digit_en = 4'h0;
        bus.blank_lz = 1'b0;
        bus.load     = 1'b0;
`ifdef SEG_DIMMING_EN
        bus.brightness = 4'hF;
`endif
        test_reset();
        test_basic_scan();
        test_leading_zero();
        test_tear_free();
        test_enable_dp();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
